// File: rtl/starship_pkg.sv
// Shared types and constants for the starship fault-injection logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: one-hot state encoding of the fault generator, LFSR feedback
// polynomial, repair-combo fallback value, maximum subsystem count and a
// helper that turns an LFSR nibble into a legal (non-zero) repair combo.
package starship_pkg;

    // Upper bound on breakable subsystems; target_idx is 3 bits wide.
    localparam int MAX_SUB = 8;

    // Galois feedback taps for the 16-bit right-shifting LFSR (maximal length).
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // A combo of zero is not a usable repair code, so it is replaced by this.
    localparam logic [3:0] COMBO_FALLBACK = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_COOLDOWN = 4'b0010,
        ST_SELECT   = 4'b0100,
        ST_REQUEST  = 4'b1000
    } fg_state_t;

    function automatic logic [3:0] combo_from_nibble(input logic [3:0] nib);
        return (nib == 4'h0) ? COMBO_FALLBACK : nib;
    endfunction

endpackage

// File: rtl/starship_fault_gen_if.sv
// Break-request bus between the fault generator and the subsystem FSMs.
// Latency: n/a (wiring only).
// Backpressure: none; a request is held until the subsystem reports broken.
//
// Signals:
//   broken     per-subsystem broken status (acknowledge), driven by subsystems
//   break_req  one-hot break request, driven by the fault generator
//   random_hex repair combo for the current target, never zero
//   target_idx index of the current or most recent target
interface starship_fault_gen_if #(
    parameter int NUM_SUB = 4
);
    logic [NUM_SUB-1:0] broken;
    logic [NUM_SUB-1:0] break_req;
    logic [3:0]         random_hex;
    logic [2:0]         target_idx;

    modport master (
        input  broken,
        output break_req,
        output random_hex,
        output target_idx
    );

    modport slave (
        output broken,
        input  break_req,
        input  random_hex,
        input  target_idx
    );
endinterface

// File: rtl/starship_lfsr16.sv
// 16-bit Galois LFSR, right shifting, reusable random source for the game.
// Latency: new value one timer_clk edge after each enabled cycle.
// Backpressure: none; en simply freezes the sequence.
//
// Ports:
//   timer_clk  clock
//   Reset      asynchronous active-high reset, loads SEED
//   en         advance the sequence on this edge
//   lfsr       current register value
// SEED must be nonzero: with a maximal polynomial the all-zero state is then
// unreachable, so no lock-up recovery logic is needed.
module starship_lfsr16
    import starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        timer_clk,
    input  logic        Reset,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/starship_fault_gen.sv
// Fault-injection initiator: schedules random break events on the subsystems.
// Latency: request asserted 1 tick after SELECT entry; outputs all registered.
// Backpressure: request held until broken[target] (ack) or REQ_TIMEOUT ticks.
//
// Ports:
//   timer_clk      slow game tick clock
//   Reset          asynchronous active-high reset
//   play_flag      game running; low forces IDLE
//   gameover_ctrl  game over; high forces IDLE (wins over play_flag)
//   sub            break bus (master side): broken in; break_req, random_hex,
//                  target_idx out
//   busy           high while a request is outstanding
//   breaks_issued  saturating count of acknowledged breaks this game
// Optional build macro FAULT_GEN_RAMP_EN: cooldown base shrinks by one every
// RAMP_STEP acknowledged breaks (floor 1); otherwise the base is MIN_GAP.
module starship_fault_gen
    import starship_pkg::*;
#(
    parameter int          NUM_SUB     = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          MIN_GAP     = 8,
    parameter logic [7:0]  GAP_MASK    = 8'h0F,
    parameter int          REQ_TIMEOUT = 16,
    parameter int          RAMP_STEP   = 4
) (
    input  logic                 timer_clk,
    input  logic                 Reset,
    input  logic                 play_flag,
    input  logic                 gameover_ctrl,
    starship_fault_gen_if.master sub,
    output logic                 busy,
    output logic [7:0]           breaks_issued
);

    fg_state_t   state;
    logic [15:0] gap_cnt;
    logic [7:0]  to_cnt;
    logic [15:0] lfsr;
    logic        abort;
    logic        ack;
    logic        found;
    logic [2:0]  pick;
    logic [MAX_SUB-1:0] broken_pad;
    logic [7:0]  gap_base;
    logic [7:0]  gap_base_ack;
    logic        unused_lfsr_bit;

    // Free-running: the sequence advances every tick whatever the state.
    starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .timer_clk (timer_clk),
        .Reset     (Reset),
        .en        (1'b1),
        .lfsr      (lfsr)
    );

    // Bit 3 is not used by any of the random fields below.
    assign unused_lfsr_bit = lfsr[3];

    assign abort = gameover_ctrl | ~play_flag;

    // Pad non-existent subsystems as "broken" so they are never chosen and
    // the 3-bit indices can address the vector directly.
    always_comb begin
        broken_pad              = '1;
        broken_pad[NUM_SUB-1:0] = sub.broken;
    end

    assign ack = broken_pad[sub.target_idx];

    // Target pick: start at lfsr[2:0] mod NUM_SUB, rotate upward to the first
    // subsystem that is not already broken. Scanning from the far end lets the
    // closest candidate overwrite the others.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int k = NUM_SUB - 1; k >= 0; k--) begin
            if (!broken_pad[3'((int'(lfsr[2:0]) % NUM_SUB + k) % NUM_SUB)]) begin
                found = 1'b1;
                pick  = 3'((int'(lfsr[2:0]) % NUM_SUB + k) % NUM_SUB);
            end
        end
    end

    function automatic logic [15:0] gap_load(input logic [7:0] base,
                                             input logic [7:0] field);
        return {8'h00, base} + {8'h00, field & GAP_MASK};
    endfunction

`ifdef FAULT_GEN_RAMP_EN
    logic [7:0] ramp_cnt;

    // Base in effect after the acknowledge currently being taken, so the
    // cooldown that follows the RAMP_STEP-th break already uses the new base.
    assign gap_base_ack = (ramp_cnt == 8'(RAMP_STEP - 1) && gap_base > 8'd1)
                        ? gap_base - 8'd1 : gap_base;

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            gap_base <= 8'(MIN_GAP);
            ramp_cnt <= 8'd0;
        end else if (abort) begin
            gap_base <= 8'(MIN_GAP);
            ramp_cnt <= 8'd0;
        end else if (state == ST_REQUEST && ack) begin
            if (ramp_cnt == 8'(RAMP_STEP - 1)) begin
                ramp_cnt <= 8'd0;
                gap_base <= gap_base_ack;
            end else begin
                ramp_cnt <= ramp_cnt + 8'd1;
            end
        end
    end
`else
    localparam int unused_ramp_step = RAMP_STEP;

    assign gap_base     = 8'(MIN_GAP);
    assign gap_base_ack = gap_base;
`endif

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state          <= ST_IDLE;
            gap_cnt        <= 16'd0;
            to_cnt         <= 8'd0;
            sub.break_req  <= '0;
            sub.random_hex <= COMBO_FALLBACK;
            sub.target_idx <= 3'd0;
            busy           <= 1'b0;
            breaks_issued  <= 8'd0;
        end else if (abort) begin
            // random_hex, target_idx and breaks_issued keep their values.
            state         <= ST_IDLE;
            sub.break_req <= '0;
            busy          <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state         <= ST_COOLDOWN;
                    gap_cnt       <= gap_load(gap_base, lfsr[11:4]);
                    breaks_issued <= 8'd0;
                end
                ST_COOLDOWN: begin
                    if (gap_cnt <= 16'd1) begin
                        gap_cnt <= 16'd0;
                        state   <= ST_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                ST_SELECT: begin
                    // With every subsystem broken we simply wait here.
                    if (found) begin
                        sub.target_idx <= pick;
                        sub.random_hex <= combo_from_nibble(lfsr[15:12]);
                        sub.break_req  <= {{(NUM_SUB-1){1'b0}}, 1'b1} << pick;
                        busy           <= 1'b1;
                        to_cnt         <= 8'd0;
                        state          <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    // Acknowledge is tested first so it wins over timeout.
                    if (ack) begin
                        sub.break_req <= '0;
                        busy          <= 1'b0;
                        if (breaks_issued != 8'hFF) begin
                            breaks_issued <= breaks_issued + 8'd1;
                        end
                        gap_cnt <= gap_load(gap_base_ack, lfsr[11:4]);
                        state   <= ST_COOLDOWN;
                    end else if (to_cnt == 8'(REQ_TIMEOUT - 1)) begin
                        sub.break_req <= '0;
                        busy          <= 1'b0;
                        gap_cnt       <= gap_load(gap_base, lfsr[11:4]);
                        state         <= ST_COOLDOWN;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    sub.break_req <= '0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
